// File: rtl/vga_pkg.sv
// Shared VGA constants, the rgb444 colour type and the cell-index helper.
package vga_pkg;

    // 640x480@60 horizontal timing, in pixel ticks
    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    // 640x480@60 vertical timing, in lines
    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // Framebuffer geometry: 40x30 cells, each 16x16 pixels
    localparam int FB_COLS    = 40;
    localparam int FB_ROWS    = 30;
    localparam int FB_BITS    = FB_COLS * FB_ROWS;
    localparam int CELL_SHIFT = 4;

    // Datapath widths
    localparam int CNT_W = 10;   // h/v counters (max 799 / 524)
    localparam int COL_W = 6;    // cell column 0..39
    localparam int ROW_W = 5;    // cell row 0..29
    localparam int IDX_W = 11;   // cell index 0..1199
    localparam int DIV_W = 3;    // pixel-tick divider, CLK_DIV up to 8

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // row*40 + col, with the multiply built from two shifts
    function automatic logic [IDX_W-1:0] cell_index(input logic [ROW_W-1:0] row,
                                                    input logic [COL_W-1:0] col);
        logic [IDX_W-1:0] row_w;
        logic [IDX_W-1:0] col_w;
        row_w = {{(IDX_W-ROW_W){1'b0}}, row};
        col_w = {{(IDX_W-COL_W){1'b0}}, col};
        return (row_w << 5) + (row_w << 3) + col_w;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-tick divider and h/v raster counters with raw sync and active flags.
module vga_timing
    import vga_pkg::*;
#(
    parameter int CLK_DIV     = 2,
    parameter int H_VIS_PX    = H_VISIBLE,
    parameter int H_FP_PX     = H_FP,
    parameter int H_SYNC_PX   = H_SYNC,
    parameter int H_BP_PX     = H_BP,
    parameter int V_VIS_LN    = V_VISIBLE,
    parameter int V_FP_LN     = V_FP,
    parameter int V_SYNC_LN   = V_SYNC,
    parameter int V_BP_LN     = V_BP
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    output logic             tick_o,
    output logic [CNT_W-1:0] h_count_o,
    output logic [CNT_W-1:0] v_count_o,
    output logic             active_o,
    output logic             hs_o,
    output logic             vs_o
);

    if (CLK_DIV < 1 || CLK_DIV > 8) begin : g_bad_clk_div
        $error("vga_timing: CLK_DIV must be in 1..8");
    end

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_VIS_END  = CNT_W'(H_VIS_PX);
    localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_VIS_PX + H_FP_PX);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_VIS_PX + H_FP_PX + H_SYNC_PX);
    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_VIS_PX + H_FP_PX + H_SYNC_PX + H_BP_PX - 1);
    localparam logic [CNT_W-1:0] V_VIS_END  = CNT_W'(V_VIS_LN);
    localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_VIS_LN + V_FP_LN);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_VIS_LN + V_FP_LN + V_SYNC_LN);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_VIS_LN + V_FP_LN + V_SYNC_LN + V_BP_LN - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic             tick;

    // With CLK_DIV=1 DIV_LAST is 0, so the tick is permanently high.
    assign tick = (div_q == DIV_LAST);

    // Next-state for the divider and the raster position
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        div_d = tick ? '0 : div_q + 1'b1;
        h_d   = h_q;
        v_d   = v_q;
        if (tick) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    // Divider and counter registers
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
        if (!reset_n_i) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

    assign tick_o    = tick;
    assign h_count_o = h_q;
    assign v_count_o = v_q;
    assign active_o  = (h_q < H_VIS_END) && (v_q < V_VIS_END);
    assign hs_o      = !((h_q >= H_SYNC_BEG) && (h_q < H_SYNC_END));
    assign vs_o      = !((v_q >= V_SYNC_BEG) && (v_q < V_SYNC_END));

endmodule

// File: rtl/vga_scanout.sv
// VGA scan-out: per-frame framebuffer snapshot, 2-tick index/colour pipeline.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int          CLK_DIV    = 2,
    parameter logic [11:0] FG_DEFAULT = 12'hFFF,
    parameter logic [11:0] BG_DEFAULT = 12'h000,
    // Raster geometry; defaults are 640x480@60, smaller values only shorten simulation
    parameter int          H_VIS_PX   = H_VISIBLE,
    parameter int          H_FP_PX    = H_FP,
    parameter int          H_SYNC_PX  = H_SYNC,
    parameter int          H_BP_PX    = H_BP,
    parameter int          V_VIS_LN   = V_VISIBLE,
    parameter int          V_FP_LN    = V_FP,
    parameter int          V_SYNC_LN  = V_SYNC,
    parameter int          V_BP_LN    = V_BP
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [FB_BITS-1:0] framebuffer,
    input  logic               fg_sel,
    input  logic [11:0]        fg_color,
    input  logic [11:0]        bg_color,
    output logic [3:0]         vga_r,
    output logic [3:0]         vga_g,
    output logic [3:0]         vga_b,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic [5:0]         xpos,
    output logic [4:0]         ypos,
    output logic               frame_start
);

    localparam logic [CNT_W-1:0] V_LOAD_LINE = CNT_W'(V_VIS_LN);

    // Stage 0: raster counters
    logic             tick;
    logic [CNT_W-1:0] h_count;
    logic [CNT_W-1:0] v_count;
    logic             active_raw;
    logic             hs_raw;
    logic             vs_raw;

    vga_timing #(
        .CLK_DIV   (CLK_DIV),
        .H_VIS_PX  (H_VIS_PX),
        .H_FP_PX   (H_FP_PX),
        .H_SYNC_PX (H_SYNC_PX),
        .H_BP_PX   (H_BP_PX),
        .V_VIS_LN  (V_VIS_LN),
        .V_FP_LN   (V_FP_LN),
        .V_SYNC_LN (V_SYNC_LN),
        .V_BP_LN   (V_BP_LN)
    ) u_timing (
        .clock_i   (clock),
        .reset_n_i (reset_n),
        .tick_o    (tick),
        .h_count_o (h_count),
        .v_count_o (v_count),
        .active_o  (active_raw),
        .hs_o      (hs_raw),
        .vs_o      (vs_raw)
    );

    // Snapshot is taken on the tick that opens vertical blanking
    logic               load;
    logic [FB_BITS-1:0] snapshot_q;
    logic               frame_start_q;

    assign load = tick && (h_count == '0) && (v_count == V_LOAD_LINE);

    // Stage 1 registers
    logic             s1_active_q, s1_active_d;
    logic             s1_hs_q,     s1_hs_d;
    logic             s1_vs_q,     s1_vs_d;
    logic [COL_W-1:0] s1_col_q,    s1_col_d;
    logic [ROW_W-1:0] s1_row_q,    s1_row_d;
    logic [IDX_W-1:0] s1_idx_q,    s1_idx_d;
    rgb444_t          s1_fg_q,     s1_fg_d;
    rgb444_t          s1_bg_q,     s1_bg_d;

    // Stage 2 (output) registers
    rgb444_t          rgb_q,  rgb_d;
    logic             hs_q;
    logic             vs_q;
    logic [COL_W-1:0] xpos_q, xpos_d;
    logic [ROW_W-1:0] ypos_q, ypos_d;

    // Stage 1 next-state: cell coordinates, cell index and colour pair
    always_comb begin
        s1_active_d = active_raw;
        s1_hs_d     = hs_raw;
        s1_vs_d     = vs_raw;
        // Blanking coordinates are zeroed so the index always stays inside the bitmap.
        s1_col_d    = active_raw ? h_count[CELL_SHIFT +: COL_W] : '0;
        s1_row_d    = active_raw ? v_count[CELL_SHIFT +: ROW_W] : '0;
        s1_idx_d    = cell_index(s1_row_d, s1_col_d);
        s1_fg_d     = fg_sel ? rgb444_t'(fg_color) : rgb444_t'(FG_DEFAULT);
        s1_bg_d     = fg_sel ? rgb444_t'(bg_color) : rgb444_t'(BG_DEFAULT);
    end

    // Stage 2 next-state: colour lookup, blanking forces black and zero coordinates
    always_comb begin
        rgb_d  = '0;
        xpos_d = '0;
        ypos_d = '0;
        if (s1_active_q) begin
            rgb_d  = snapshot_q[s1_idx_q] ? s1_fg_q : s1_bg_q;
            xpos_d = s1_col_q;
            ypos_d = s1_row_q;
        end
    end

    // Frame snapshot and the frame_start pulse that marks its load
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: the snapshot is reset on purpose: the first frame after reset must show background.
        if (!reset_n) begin
            snapshot_q    <= '0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= load;
            if (load) begin
                snapshot_q <= framebuffer;
            end
        end
    end

    // Stage 1 pipeline registers, advanced on the pixel tick
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_active_q <= 1'b0;
            s1_hs_q     <= 1'b1;
            s1_vs_q     <= 1'b1;
            s1_col_q    <= '0;
            s1_row_q    <= '0;
            s1_idx_q    <= '0;
            s1_fg_q     <= '0;
            s1_bg_q     <= '0;
        end else if (tick) begin
            s1_active_q <= s1_active_d;
            s1_hs_q     <= s1_hs_d;
            s1_vs_q     <= s1_vs_d;
            s1_col_q    <= s1_col_d;
            s1_row_q    <= s1_row_d;
            s1_idx_q    <= s1_idx_d;
            s1_fg_q     <= s1_fg_d;
            s1_bg_q     <= s1_bg_d;
        end
    end

    // Stage 2 output registers, keeping colour and sync aligned
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rgb_q  <= '0;
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
            xpos_q <= '0;
            ypos_q <= '0;
        end else if (tick) begin
            rgb_q  <= rgb_d;
            hs_q   <= s1_hs_q;
            vs_q   <= s1_vs_q;
            xpos_q <= xpos_d;
            ypos_q <= ypos_d;
        end
    end

    assign vga_r       = rgb_q.r;
    assign vga_g       = rgb_q.g;
    assign vga_b       = rgb_q.b;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign xpos        = xpos_q;
    assign ypos        = ypos_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout: a shrunken raster (4x3 cells) for the frame
// behaviour, plus a full 640x480 instance with CLK_DIV=1 for line timing.
module tb_vga_scanout;
    import vga_pkg::*;

    // Shrunken raster for the main instance
    localparam int CD  = 2;
    localparam int HV  = 64, HF = 4, HSY = 8, HB = 4;
    localparam int VV  = 48, VF = 2, VSY = 2, VB = 3;
    localparam int HT  = HV + HF + HSY + HB;   // 80
    localparam int VT  = VV + VF + VSY + VB;   // 55
    localparam int FT  = HT * VT;              // 4400 ticks per frame

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic               reset_n;
    logic               rst_d_n;
    logic [FB_BITS-1:0] framebuffer;
    logic               fg_sel;
    logic [11:0]        fg_color;
    logic [11:0]        bg_color;

    logic [3:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, frame_start;
    logic [5:0] xpos;
    logic [4:0] ypos;

    logic [3:0] d_r, d_g, d_b;
    logic       d_hs, d_vs, d_fs;
    logic [5:0] d_xpos;
    logic [4:0] d_ypos;

    vga_scanout #(
        .CLK_DIV    (CD),
        .FG_DEFAULT (12'hFFF),
        .BG_DEFAULT (12'h000),
        .H_VIS_PX   (HV),
        .H_FP_PX    (HF),
        .H_SYNC_PX  (HSY),
        .H_BP_PX    (HB),
        .V_VIS_LN   (VV),
        .V_FP_LN    (VF),
        .V_SYNC_LN  (VSY),
        .V_BP_LN    (VB)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .framebuffer (framebuffer),
        .fg_sel      (fg_sel),
        .fg_color    (fg_color),
        .bg_color    (bg_color),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .xpos        (xpos),
        .ypos        (ypos),
        .frame_start (frame_start)
    );

    vga_scanout #(
        .CLK_DIV (1)
    ) dut_d (
        .clock       (clock),
        .reset_n     (rst_d_n),
        .framebuffer ('0),
        .fg_sel      (1'b0),
        .fg_color    (12'h000),
        .bg_color    (12'h000),
        .vga_r       (d_r),
        .vga_g       (d_g),
        .vga_b       (d_b),
        .vga_hs      (d_hs),
        .vga_vs      (d_vs),
        .xpos        (d_xpos),
        .ypos        (d_ypos),
        .frame_start (d_fs)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Clock edges since reset release, per instance
    int cyc;
    int cyc_d;
    always @(posedge clock or negedge reset_n)
        if (!reset_n) cyc <= 0; else cyc <= cyc + 1;
    always @(posedge clock or negedge rst_d_n)
        if (!rst_d_n) cyc_d <= 0; else cyc_d <= cyc_d + 1;

    // Scoreboard of expected output pixels, keyed by raster position
    typedef struct {
        string      name;
        int         pos;
        logic [11:0] rgb;
        logic       hs;
        logic       vs;
        logic [5:0] x;
        logic [4:0] y;
    } exp_t;

    exp_t sbq[$];

    task automatic push_px(input string name, input int f, input int h, input int v,
                           input logic [11:0] rgb, input logic hs, input logic vs,
                           input logic [5:0] x, input logic [4:0] y);
        exp_t e;
        e.name = name;
        e.pos  = f * FT + v * HT + h;
        e.rgb  = rgb;
        e.hs   = hs;
        e.vs   = vs;
        e.x    = x;
        e.y    = y;
        sbq.push_back(e);
    endtask

    // Monitor: the pixel sampled by counters at position L is on the outputs
    // after clock edge CD*(L+2), i.e. two ticks later.
    initial begin : monitor
        exp_t e;
        int   pos;
        forever begin
            @(negedge clock);
            if (reset_n && cyc >= 2 * CD && sbq.size() > 0) begin
                pos = cyc / CD - 2;
                if (sbq[0].pos <= pos) begin
                    e = sbq.pop_front();
                    if (e.pos < pos) begin
                        check({e.name, "/missed"}, 64'(pos), 64'(e.pos));
                    end else begin
                        check({e.name, "/rgb"},  {vga_r, vga_g, vga_b}, e.rgb);
                        check({e.name, "/sync"}, {vga_hs, vga_vs}, {e.hs, e.vs});
                        check({e.name, "/pos"},  {xpos, ypos}, {e.x, e.y});
                    end
                end
            end
        end
    end

    // Wait (at negedges) until the main instance has seen `target` edges
    task automatic wait_cyc(input int target);
        int guard;
        guard = 0;
        while (cyc < target && guard < 40000) begin
            @(negedge clock);
            guard++;
        end
        if (cyc < target) check("wait_cyc_timeout", 64'(cyc), 64'(target));
    endtask

    function automatic logic [FB_BITS-1:0] one_bit(input int idx);
        logic [FB_BITS-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Full-size instance: column decode and hsync width/period in clocks
    logic d_done = 1'b0;
    initial begin : dflt_timing
        int t_fall, t_rise, t_fall2, guard;
        @(posedge rst_d_n);
        while (cyc_d < 625) @(negedge clock);
        check("d_xpos_h623", d_xpos, 6'd38);
        @(negedge clock);
        check("d_xpos_h624", d_xpos, 6'd39);
        while (cyc_d < 642) @(negedge clock);
        check("d_xpos_h640_blank", d_xpos, 6'd0);
        guard = 0;
        while (d_hs !== 1'b0 && guard < 2000) begin @(negedge clock); guard++; end
        t_fall = cyc_d;
        check("d_hs_first_fall", 64'(t_fall), 64'(658));
        guard = 0;
        while (d_hs !== 1'b1 && guard < 2000) begin @(negedge clock); guard++; end
        t_rise = cyc_d;
        check("d_hs_low_width", 64'(t_rise - t_fall), 64'(96));
        guard = 0;
        while (d_hs !== 1'b0 && guard < 2000) begin @(negedge clock); guard++; end
        t_fall2 = cyc_d;
        check("d_hs_period", 64'(t_fall2 - t_fall), 64'(800));
        d_done = 1'b1;
    end

    localparam int E0 = CD * (VV * HT + 1);        // edge that loads frame 0's snapshot
    localparam int E1 = CD * (FT + VV * HT + 1);   // edge that loads frame 1's snapshot

    initial begin : stimulus
        reset_n     = 1'b0;
        rst_d_n     = 1'b0;
        framebuffer = one_bit(0);
        fg_sel      = 1'b1;
        fg_color    = 12'hF00;
        bg_color    = 12'h00F;

        // Frame 0: snapshot still zero, so every active pixel is background blue
        push_px("f0_0_0",   0,  0,  0, 12'h00F, 1, 1, 0, 0);
        push_px("f0_47_0",  0, 47,  0, 12'h00F, 1, 1, 2, 0);
        push_px("f0_48_0",  0, 48,  0, 12'h00F, 1, 1, 3, 0);
        push_px("f0_64_0",  0, 64,  0, 12'h000, 1, 1, 0, 0);
        push_px("f0_67_0",  0, 67,  0, 12'h000, 1, 1, 0, 0);
        push_px("f0_68_0",  0, 68,  0, 12'h000, 0, 1, 0, 0);
        push_px("f0_75_0",  0, 75,  0, 12'h000, 0, 1, 0, 0);
        push_px("f0_76_0",  0, 76,  0, 12'h000, 1, 1, 0, 0);
        push_px("f0_15_16", 0, 15, 16, 12'h00F, 1, 1, 0, 1);
        push_px("f0_63_47", 0, 63, 47, 12'h00F, 1, 1, 3, 2);
        push_px("f0_0_49",  0,  0, 49, 12'h000, 1, 1, 0, 0);
        push_px("f0_0_50",  0,  0, 50, 12'h000, 1, 0, 0, 0);
        push_px("f0_79_51", 0, 79, 51, 12'h000, 1, 0, 0, 0);
        push_px("f0_0_52",  0,  0, 52, 12'h000, 1, 1, 0, 0);
        push_px("f0_0_54",  0,  0, 54, 12'h000, 1, 1, 0, 0);
        // Frame 1: snapshot holds bit 0, default colours (white on black)
        push_px("f1_0_0",   1,  0,  0, 12'hFFF, 1, 1, 0, 0);
        push_px("f1_15_15", 1, 15, 15, 12'hFFF, 1, 1, 0, 0);
        push_px("f1_16_15", 1, 16, 15, 12'h000, 1, 1, 1, 0);
        push_px("f1_0_16",  1,  0, 16, 12'h000, 1, 1, 0, 1);
        // framebuffer switched to bit 83 at line 20: no effect this frame
        push_px("f1_50_40", 1, 50, 40, 12'h00F, 1, 1, 3, 2);
        push_px("f1_63_47", 1, 63, 47, 12'h00F, 1, 1, 3, 2);
        // Frame 2: only the last cell (col 3, row 2 = bit 83) is red
        push_px("f2_0_0",   2,  0,  0, 12'h00F, 1, 1, 0, 0);
        push_px("f2_48_31", 2, 48, 31, 12'h00F, 1, 1, 3, 1);
        push_px("f2_47_32", 2, 47, 32, 12'h00F, 1, 1, 2, 2);
        push_px("f2_48_32", 2, 48, 32, 12'hF00, 1, 1, 3, 2);
        push_px("f2_63_47", 2, 63, 47, 12'hF00, 1, 1, 3, 2);
        push_px("f2_64_47", 2, 64, 47, 12'h000, 1, 1, 0, 0);

        repeat (3) @(negedge clock);
        check("rst_rgb",  {vga_r, vga_g, vga_b}, 12'h000);
        check("rst_sync", {vga_hs, vga_vs}, 2'b11);
        check("rst_pos",  {xpos, ypos}, 11'd0);
        check("rst_fs",   frame_start, 1'b0);
        check("rst_d_all", {d_r, d_g, d_b, d_hs, d_vs, d_xpos, d_ypos, d_fs},
              {12'h000, 1'b1, 1'b1, 6'd0, 5'd0, 1'b0});
        reset_n = 1'b1;
        rst_d_n = 1'b1;

        // frame_start is a single-clock pulse on the snapshot edge
        wait_cyc(E0 - 1);
        check("f0_fs_before", frame_start, 1'b0);
        wait_cyc(E0);
        check("f0_fs_pulse", frame_start, 1'b1);
        wait_cyc(E0 + 1);
        check("f0_fs_after", frame_start, 1'b0);

        wait_cyc(CD * (50 * HT));
        fg_sel = 1'b0;

        wait_cyc(CD * (FT + 20 * HT));
        framebuffer = one_bit(83);
        fg_sel      = 1'b1;

        wait_cyc(E1);
        check("f1_fs_pulse", frame_start, 1'b1);

        // Reset in frame 3 while a blue pixel (col 1, row 1) is on the outputs
        wait_cyc(CD * (3 * FT + 20 * HT + 30));
        check("sb_drained_pre_reset", 64'(sbq.size()), 64'(0));
        reset_n = 1'b0;
        #1;
        check("mid_rst_rgb",  {vga_r, vga_g, vga_b}, 12'h000);
        check("mid_rst_sync", {vga_hs, vga_vs}, 2'b11);
        check("mid_rst_pos",  {xpos, ypos}, 11'd0);
        repeat (4) @(negedge clock);
        reset_n = 1'b1;

        // After release: timing restarts at (0,0) and the snapshot is zero again
        push_px("r0_0_0",   0,  0,  0, 12'h00F, 1, 1, 0, 0);
        push_px("r0_68_0",  0, 68,  0, 12'h000, 0, 1, 0, 0);
        push_px("r0_48_32", 0, 48, 32, 12'h00F, 1, 1, 3, 2);

        wait_cyc(E0);
        check("r0_fs_pulse", frame_start, 1'b1);
        check("sb_drained_end", 64'(sbq.size()), 64'(0));

        wait (d_done);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
Scan-out end of the 40x30 framebuffer interface. It generates 640x480@60 VGA timing from the board clock and reads the 1200-bit framebuffer written by the display-composition logic. Each framebuffer bit is drawn as a 16x16-pixel cell in foreground or background colour. The framebuffer is snapshotted once per frame at vblank start, so mid-frame writes cannot cause tearing.

Parameters:
CLK_DIV, 2, board clocks per pixel tick (50 MHz clock gives a 25 MHz pixel rate); legal range 1..8
FG_DEFAULT, 12'hFFF, foreground colour driven when fg_sel=0
BG_DEFAULT, 12'h000, background colour driven when fg_sel=0

Ports:
clock  in  1  board clock; all state on rising edge
reset_n  in  1  asynchronous, active-low reset
framebuffer  in  1200  cell bitmap; cell (col,row) = bit row*40+col, col 0..39 left to right, row 0..29 top to bottom; 1 = foreground
fg_sel  in  1  1 = use fg_color/bg_color, 0 = use the default parameters
fg_color  in  12  {R[3:0],G[3:0],B[3:0]} foreground colour
bg_color  in  12  background colour, same packing
vga_r, vga_g, vga_b  out  4 each  pixel colour; 0 outside the active area
vga_hs  out  1  horizontal sync, active-low
vga_vs  out  1  vertical sync, active-low
xpos  out  6  cell column currently being drawn (0..39); 0 when not active
ypos  out  5  cell row currently being drawn (0..29); 0 when not active
frame_start  out  1  one-clock pulse at vblank start, coincident with the snapshot load

Behaviour:
- Reset (async assert, sync-released by the user's reset tree): all counters 0; snapshot all 0; vga_r/g/b=0; vga_hs=1; vga_vs=1; xpos=0; ypos=0; frame_start=0.
- Pixel tick: div counter runs 0..CLK_DIV-1. tick=1 on the clock where the count = CLK_DIV-1. With CLK_DIV=1, tick is always 1. All timing state advances only on tick.
- h_count runs 0..799 and wraps. v_count increments when h_count wraps and itself wraps 0..524.
- Horizontal timing: visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
- Vertical timing: visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
- Active = h_count<640 and v_count<480. Cell col = h_count[9:4]; cell row = v_count[8:4].
- Pipeline, 2 ticks total, stage 0 = counters:
  - Stage 1 registers active, sync levels, cell index = row*40+col (11 bits; the multiply is done as (row<<5)+(row<<3)).
  - Stage 2 registers colour from snapshot[index], plus delayed sync, xpos and ypos.
  - Outputs therefore lag the counters by exactly 2 ticks. hs, vs and colour stay mutually aligned.
- Colour select: stage-1 active=0 forces 0. Otherwise the snapshot bit selects fg/bg. fg_sel is sampled in stage 1.
- Snapshot load:
  - Loads framebuffer into the internal 1200-bit register on the tick where h_count=0 and v_count=480.
  - frame_start pulses for that single clock.
  - The first frame after reset displays all background (snapshot=0).
- framebuffer changes at any other time have no visible effect until the next snapshot.
- Reset mid-frame: counters restart at (0,0) and the outputs return to their reset values immediately, with no partial line.
- xpos/ypos are held at 0 during blanking.

Decomposition:
- Package vga_pkg: H_VISIBLE=640, H_FP=16, H_SYNC=96, H_BP=48, H_TOTAL=800, V_VISIBLE=480, V_FP=10, V_SYNC=2, V_BP=33, V_TOTAL=525, FB_COLS=40, FB_ROWS=30, FB_BITS=1200, CELL_SHIFT=4, and a 12-bit rgb444 colour typedef.
- Sub-module vga_timing (tick divider, h/v counters, raw sync and active) is natural. vga_scanout adds the snapshot, the index pipeline and colour muxing.

Test Plan:
- Reset then run 2 frames, CLK_DIV=2 -> hs low width 192 clocks; hs period 1600 clocks; vs low for 2 lines (3200 clocks); frame period 840000 clocks.
- framebuffer bit 0 = 1, others 0, fg_sel=0, wait one snapshot -> next frame drives 12'hFFF for pixels x 0..15, y 0..15 only; all other active pixels 0.
- Set bit 1199 (col 39, row 29), fg_sel=1, fg=12'hF00, bg=12'h00F -> only pixels x 624..639, y 464..479 are red; other active pixels blue; blanking is 0.
- Toggle framebuffer mid-frame (v_count=200) -> current frame unchanged; change appears after the next frame_start.
- Align check: first active pixel (h=0,v=0) appears on the output 2 ticks after the counters reach (0,0); xpos=0, ypos=0 there; xpos=39 at h=624.
- Assert reset_n low at v_count=300 -> outputs return to reset values immediately; after release, hs/vs timing restarts from (0,0) and the snapshot is 0 until line 480.
